// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction input side, decoded output side
// and the two event counters.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [CNT_W-1:0] cnt_total;
    logic [CNT_W-1:0] cnt_illegal;

    modport master (
        output in_valid, inst, out_ready,
        input  in_ready, out_valid, imm, fmt, illegal, cnt_total, cnt_illegal
    );

    modport slave (
        input  in_valid, inst, out_ready,
        output in_ready, out_valid, imm, fmt, illegal, cnt_total, cnt_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: one-cycle decode into an output
// register backed by a one-entry skid buffer, with flush and saturating counters.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHIFT = 3'd6;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t                   d;
        logic [6:0]             op;
        logic [2:0]             f3;
        logic                   is_shift;
        logic signed [XLEN-1:0] ext;
        logic signed [11:0]     imm_i;
        logic signed [11:0]     imm_s;
        logic signed [12:0]     imm_b;
        logic signed [31:0]     imm_u;
        logic signed [20:0]     imm_j;

        op       = ir[6:0];
        f3       = ir[14:12];
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        imm_i    = ir[31:20];
        imm_s    = {ir[31:25], ir[11:7]};
        imm_b    = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        imm_u    = {ir[31:12], 12'b0};
        imm_j    = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

        ext   = '0;
        d.fmt = FMT_R;
        d.ill = 1'b0;

        case (op)
            OP_LOAD, OP_MISC_MEM, OP_JALR, OP_SYSTEM: begin
                ext   = XLEN'(imm_i);
                d.fmt = FMT_I;
            end
            OP_IMM: begin
                if (is_shift) begin
                    // Shift amount only; funct7 bits above it never leak into imm.
                    ext[4:0] = ir[24:20];
                    if (XLEN == 64) ext[5] = ir[25];
                    d.fmt = FMT_SHIFT;
                end else begin
                    ext   = XLEN'(imm_i);
                    d.fmt = FMT_I;
                end
            end
            OP_IMM_32: begin
                if (XLEN == 64 && f3 == 3'b000) begin
                    ext   = XLEN'(imm_i);
                    d.fmt = FMT_I;
                end else if (XLEN == 64 && is_shift) begin
                    ext[4:0] = ir[24:20];
                    d.fmt    = FMT_SHIFT;
                end else begin
                    d.ill = 1'b1;
                end
            end
            OP_STORE: begin
                ext   = XLEN'(imm_s);
                d.fmt = FMT_S;
            end
            OP_BRANCH: begin
                ext   = XLEN'(imm_b);
                d.fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                ext   = XLEN'(imm_u);
                d.fmt = FMT_U;
            end
            OP_JAL: begin
                ext   = XLEN'(imm_j);
                d.fmt = FMT_J;
            end
            OP_OP: begin
                d.fmt = FMT_R;
            end
            OP_OP_32: begin
                d.ill = (XLEN != 64);
            end
            default: begin
                d.ill = 1'b1;
            end
        endcase

        if (d.ill) begin
            d.imm = '0;
            d.fmt = FMT_R;
        end else begin
            d.imm = ext;
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Stage p0: combinational decode of the presented instruction
    dec_t dec_p0;
    logic accept_p0;
    logic pop_p1;

    dec_t             out_p1;
    logic             vld_p1;
    dec_t             skid_p1;
    logic             skid_vld_p1;
    logic [CNT_W-1:0] cnt_total_q;
    logic [CNT_W-1:0] cnt_illegal_q;

    assign dec_p0    = decode(bus.inst);
    assign accept_p0 = bus.in_valid && !skid_vld_p1;
    assign pop_p1    = vld_p1 && bus.out_ready;

    // Stage p1: output register with one-entry skid behind it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            out_p1        <= '0;
            skid_vld_p1   <= 1'b0;
            skid_p1       <= '0;
            cnt_total_q   <= '0;
            cnt_illegal_q <= '0;
        end else begin
            if (accept_p0) begin
                cnt_total_q <= sat_inc(cnt_total_q);
                if (dec_p0.ill) cnt_illegal_q <= sat_inc(cnt_illegal_q);
            end

            if (flush) begin
                vld_p1      <= 1'b0;
                skid_vld_p1 <= 1'b0;
            end else if (!vld_p1 || pop_p1) begin
                // A full skid blocks new accepts, so it is always the older entry.
                if (skid_vld_p1) begin
                    out_p1      <= skid_p1;
                    vld_p1      <= 1'b1;
                    skid_vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= accept_p0;
                    if (accept_p0) out_p1 <= dec_p0;
                end
            end else if (accept_p0) begin
                skid_p1     <= dec_p0;
                skid_vld_p1 <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = !skid_vld_p1;
    assign bus.out_valid   = vld_p1;
    assign bus.imm         = out_p1.imm;
    assign bus.fmt         = out_p1.fmt;
    assign bus.illegal     = out_p1.ill;
    assign bus.cnt_total   = cnt_total_q;
    assign bus.cnt_illegal = cnt_illegal_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised and directed bench for imm_gen_pipe at XLEN=64 (small counters)
// and XLEN=32, with a queue-based behavioural model.
module tb_imm_gen_pipe;

    localparam int CW  = 5;
    localparam int SAT = 31;

    logic clk;
    logic reset;
    logic flush;

    imm_gen_pipe_if #(.XLEN(64), .CNT_W(CW)) bus64();
    imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) bus32();

    imm_gen_pipe #(.XLEN(64), .CNT_W(CW)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus64.slave)
    );
    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus32.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   m_total;
    int   m_ill;
    int   checks;
    int   failures;

    // Immediate value rebuilt from field weights rather than bit concatenation.
    function automatic exp_t ref_decode(input logic [31:0] i, input int xlen);
        exp_t       e;
        longint     v;
        logic [6:0] op;
        logic [2:0] f3;
        bit         shamt_f3;
        op       = i[6:0];
        f3       = i[14:12];
        shamt_f3 = (f3 == 3'd1) || (f3 == 3'd5);
        v        = 0;
        e.fmt    = 3'd0;
        e.ill    = 1'b0;
        if (op == 7'h03 || op == 7'h0F || op == 7'h67 || op == 7'h73 ||
            (op == 7'h13 && !shamt_f3) || (op == 7'h1B && xlen == 64 && f3 == 3'd0)) begin
            v = longint'(i[31:20]) - (i[31] ? 4096 : 0);
            e.fmt = 3'd1;
        end else if (op == 7'h13) begin
            v = (xlen == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
            e.fmt = 3'd6;
        end else if (op == 7'h1B && xlen == 64 && shamt_f3) begin
            v = longint'(i[24:20]);
            e.fmt = 3'd6;
        end else if (op == 7'h23) begin
            v = longint'(i[31:25]) * 32 + longint'(i[11:7]) - (i[31] ? 4096 : 0);
            e.fmt = 3'd2;
        end else if (op == 7'h63) begin
            v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2
                - (i[31] ? 4096 : 0);
            e.fmt = 3'd3;
        end else if (op == 7'h37 || op == 7'h17) begin
            v = longint'(i[31:12]) * 4096 - (i[31] ? 64'sd4294967296 : 64'sd0);
            e.fmt = 3'd4;
        end else if (op == 7'h6F) begin
            v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2
                - (i[31] ? 1048576 : 0);
            e.fmt = 3'd5;
        end else if (op == 7'h33 || (op == 7'h3B && xlen == 64)) begin
            v = 0;
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) e.imm = 64'd0;
        else if (xlen == 32) e.imm = {32'd0, v[31:0]};
        else e.imm = v;
        return e;
    endfunction

    function automatic int sat(input int c);
        return (c >= SAT) ? SAT : c + 1;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [14];
        ops = '{7'h03, 7'h0F, 7'h67, 7'h73, 7'h13, 7'h1B, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 13)];
        return r;
    endfunction

    // Advance one clock, keeping the model in step with the handshake.
    task automatic tick();
        bit   acc;
        bit   pop;
        exp_t e;
        acc = (bus64.in_valid === 1'b1) && (q.size() < 2) && !reset;
        pop = (bus64.out_ready === 1'b1) && (q.size() != 0) && !reset;
        e   = ref_decode(bus64.inst, 64);
        if (acc) begin
            m_total = sat(m_total);
            if (e.ill) m_ill = sat(m_ill);
        end
        if (pop) void'(q.pop_front());
        if (flush) q.delete();
        else if (acc) q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", bus64.out_valid); end
        checks++; if (bus64.imm !== 64'd0) begin failures++; $display("FAIL rst_imm got=%0h exp=0", bus64.imm); end
        checks++; if (bus64.fmt !== 3'd0 || bus64.illegal !== 1'b0) begin failures++; $display("FAIL rst_fmt_ill got=%0h/%0h exp=0/0", bus64.fmt, bus64.illegal); end
        checks++; if (bus64.cnt_total !== '0 || bus64.cnt_illegal !== '0) begin failures++; $display("FAIL rst_cnt got=%0h/%0h exp=0/0", bus64.cnt_total, bus64.cnt_illegal); end
        checks++; if (bus64.in_ready !== 1'b1 || bus32.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h/%0h exp=1/1", bus64.in_ready, bus32.in_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        bus64.out_ready = 1'b1;
        bus64.in_valid  = 1'b1;
        bus64.inst      = 32'hFFF00093;
        tick();
        checks++; if (bus64.out_valid !== 1'b1 || bus64.imm !== 64'hFFFFFFFFFFFFFFFF || bus64.fmt !== 3'd1) begin failures++; $display("FAIL addi got=%0h/%0h/%0h exp=1/ffffffffffffffff/1", bus64.out_valid, bus64.imm, bus64.fmt); end
        bus64.inst = 32'h43F0D093;
        tick();
        checks++; if (bus64.imm !== 64'h3F || bus64.fmt !== 3'd6) begin failures++; $display("FAIL srai got=%0h/%0h exp=3f/6", bus64.imm, bus64.fmt); end
        bus64.inst = 32'hFE000EE3;
        tick();
        checks++; if (bus64.imm !== 64'hFFFFFFFFFFFFFFFC || bus64.fmt !== 3'd3) begin failures++; $display("FAIL beq got=%0h/%0h exp=fffffffffffffffc/3", bus64.imm, bus64.fmt); end
        bus64.inst = 32'h800000B7;
        tick();
        checks++; if (bus64.imm !== 64'hFFFFFFFF80000000 || bus64.fmt !== 3'd4) begin failures++; $display("FAIL lui got=%0h/%0h exp=ffffffff80000000/4", bus64.imm, bus64.fmt); end
        bus64.in_valid = 1'b0;
        tick();
        checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0h exp=0", bus64.out_valid); end
        checks++; if (bus64.cnt_total !== 5'd4 || bus64.cnt_illegal !== 5'd0) begin failures++; $display("FAIL dir_cnt got=%0h/%0h exp=4/0", bus64.cnt_total, bus64.cnt_illegal); end
    endtask

    task automatic test_illegal();
        bus64.in_valid = 1'b1;
        bus64.inst     = 32'h0000007F;
        tick();
        bus64.in_valid = 1'b0;
        checks++; if (bus64.illegal !== 1'b1 || bus64.imm !== 64'd0 || bus64.fmt !== 3'd0) begin failures++; $display("FAIL ill64 got=%0h/%0h/%0h exp=1/0/0", bus64.illegal, bus64.imm, bus64.fmt); end
        checks++; if (bus64.cnt_illegal !== 5'd1 || bus64.cnt_total !== 5'd5) begin failures++; $display("FAIL ill64_cnt got=%0h/%0h exp=1/5", bus64.cnt_illegal, bus64.cnt_total); end
        bus32.out_ready = 1'b1;
        bus32.in_valid  = 1'b1;
        bus32.inst      = 32'h0000001B;
        tick();
        checks++; if (bus32.out_valid !== 1'b1 || bus32.illegal !== 1'b1 || bus32.imm !== 32'd0) begin failures++; $display("FAIL ill32 got=%0h/%0h/%0h exp=1/1/0", bus32.out_valid, bus32.illegal, bus32.imm); end
        bus32.inst = 32'h43F0D093;
        tick();
        checks++; if (bus32.illegal !== 1'b0 || bus32.imm !== 32'h1F || bus32.fmt !== 3'd6) begin failures++; $display("FAIL srai32 got=%0h/%0h/%0h exp=0/1f/6", bus32.illegal, bus32.imm, bus32.fmt); end
        bus32.inst = 32'h800000B7;
        tick();
        checks++; if (bus32.imm !== 32'h80000000 || bus32.fmt !== 3'd4) begin failures++; $display("FAIL lui32 got=%0h/%0h exp=80000000/4", bus32.imm, bus32.fmt); end
        bus32.in_valid = 1'b0;
        tick();
        checks++; if (bus32.cnt_illegal !== 16'd1 || bus32.cnt_total !== 16'd3) begin failures++; $display("FAIL cnt32 got=%0h/%0h exp=1/3", bus32.cnt_illegal, bus32.cnt_total); end
    endtask

    task automatic test_backpressure();
        bus64.out_ready = 1'b0;
        bus64.in_valid  = 1'b1;
        bus64.inst      = 32'h00500093;
        checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%0h exp=1", bus64.in_ready); end
        tick();
        bus64.inst = 32'hFE112E23;
        checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0h exp=1", bus64.in_ready); end
        tick();
        bus64.inst = 32'h0000006F;
        checks++; if (bus64.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%0h exp=0", bus64.in_ready); end
        tick();
        checks++; if (bus64.in_ready !== 1'b0 || bus64.out_valid !== 1'b1 || bus64.imm !== 64'd5) begin failures++; $display("FAIL bp_hold got=%0h/%0h/%0h exp=0/1/5", bus64.in_ready, bus64.out_valid, bus64.imm); end
        bus64.in_valid  = 1'b0;
        bus64.out_ready = 1'b1;
        tick();
        checks++; if (bus64.out_valid !== 1'b1 || bus64.imm !== 64'hFFFFFFFFFFFFFFFC || bus64.fmt !== 3'd2) begin failures++; $display("FAIL bp_second got=%0h/%0h/%0h exp=1/fffffffffffffffc/2", bus64.out_valid, bus64.imm, bus64.fmt); end
        checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL bp_reopen got=%0h exp=1", bus64.in_ready); end
        tick();
        checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0h exp=0", bus64.out_valid); end
    endtask

    task automatic fill_stalled();
        bus64.out_ready = 1'b0;
        bus64.in_valid  = 1'b1;
        bus64.inst      = rand_inst();
        tick();
        bus64.inst = rand_inst();
        tick();
        bus64.in_valid = 1'b0;
    endtask

    task automatic test_flush();
        int t0;
        fill_stalled();
        checks++; if (bus64.in_ready !== 1'b0) begin failures++; $display("FAIL fl_full got=%0h exp=0", bus64.in_ready); end
        t0 = m_total;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin failures++; $display("FAIL fl_clear got=%0h/%0h exp=0/1", bus64.out_valid, bus64.in_ready); end
        checks++; if (bus64.cnt_total !== 5'(t0) || bus64.cnt_illegal !== 5'(m_ill)) begin failures++; $display("FAIL fl_cnt got=%0h/%0h exp=%0h/%0h", bus64.cnt_total, bus64.cnt_illegal, t0, m_ill); end
        bus64.out_ready = 1'b1;
        bus64.in_valid  = 1'b1;
        bus64.inst      = 32'h00500093;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus64.in_valid = 1'b0;
        checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL fl_discard got=%0h exp=0", bus64.out_valid); end
    endtask

    task automatic test_reset_stall();
        fill_stalled();
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        m_total = 0;
        m_ill   = 0;
        checks++; if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin failures++; $display("FAIL rs_clear got=%0h/%0h exp=0/1", bus64.out_valid, bus64.in_ready); end
        checks++; if (bus64.cnt_total !== '0 || bus64.cnt_illegal !== '0) begin failures++; $display("FAIL rs_cnt got=%0h/%0h exp=0/0", bus64.cnt_total, bus64.cnt_illegal); end
        tick();
        reset = 1'b0;
        bus64.out_ready = 1'b1;
        tick();
        checks++; if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin failures++; $display("FAIL rs_after got=%0h/%0h exp=0/1", bus64.out_valid, bus64.in_ready); end
    endtask

    task automatic test_random(input int n, input int vld_pct, input int rdy_pct, input int fl_pct);
        for (int k = 0; k < n; k++) begin
            bus64.in_valid  = ($urandom_range(0, 99) < vld_pct);
            bus64.out_ready = ($urandom_range(0, 99) < rdy_pct);
            bus64.inst      = rand_inst();
            flush           = ($urandom_range(0, 99) < fl_pct);
            checks++; if (bus64.in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0h exp=%0h", k, bus64.in_ready, q.size() < 2); end
            checks++; if (bus64.out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%0h exp=%0h", k, bus64.out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++;
                if (bus64.imm !== q[0].imm || bus64.fmt !== q[0].fmt || bus64.illegal !== q[0].ill) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", k, bus64.imm, bus64.fmt, bus64.illegal, q[0].imm, q[0].fmt, q[0].ill);
                end
            end
            checks++; if (bus64.cnt_total !== 5'(m_total) || bus64.cnt_illegal !== 5'(m_ill)) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0h/%0h exp=%0h/%0h", k, bus64.cnt_total, bus64.cnt_illegal, m_total, m_ill); end
            tick();
        end
        flush          = 1'b0;
        bus64.in_valid = 1'b0;
        bus64.out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        test_random(1, 100, 100, 0);
        bus64.in_valid  = 1'b1;
        bus64.out_ready = 1'b1;
        bus64.inst      = rand_inst();
        tick();
        for (int k = 0; k < 20; k++) begin
            bus64.inst = rand_inst();
            checks++;
            if (bus64.out_valid !== 1'b1 || bus64.in_ready !== 1'b1 || q.size() != 1 ||
                bus64.imm !== q[0].imm || bus64.fmt !== q[0].fmt) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%0h/%0h/%0h exp=1/1/%0h", k, bus64.out_valid, bus64.in_ready, bus64.imm, (q.size() != 0) ? q[0].imm : 64'd0);
            end
            tick();
        end
        bus64.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        bus64.out_ready = 1'b1;
        bus64.in_valid  = 1'b1;
        bus64.inst      = 32'hFFFFFFFF;
        repeat (40) tick();
        bus64.in_valid = 1'b0;
        tick();
        checks++; if (bus64.cnt_total !== 5'h1F || bus64.cnt_illegal !== 5'h1F) begin failures++; $display("FAIL sat got=%0h/%0h exp=1f/1f", bus64.cnt_total, bus64.cnt_illegal); end
        checks++; if (bus64.cnt_total !== 5'(m_total) || bus64.cnt_illegal !== 5'(m_ill)) begin failures++; $display("FAIL sat_model got=%0h/%0h exp=%0h/%0h", bus64.cnt_total, bus64.cnt_illegal, m_total, m_ill); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        m_total         = 0;
        m_ill           = 0;
        reset           = 1'b1;
        flush           = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.inst      = 32'd0;
        bus64.out_ready = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.inst      = 32'd0;
        bus32.out_ready = 1'b1;

        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_stall();
        test_random(400, 70, 60, 3);
        test_back_to_back();
        test_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
